// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner and multi-cycle MULT/MULTU/DIV/DIVU sequencer for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one iteration per cycle.
module hilo_muldiv_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] hilo_wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [1:0]         op;
  logic [WIDTH-1:0]   x;        // dividend/multiplicand as latched (raw)
  logic [WIDTH-1:0]   y;        // divisor/multiplier, magnitude after PREP
  logic [2*WIDTH-1:0] acc;      // product, or {remainder, quotient}
  logic [CW-1:0]      cnt;
  logic               neg_q;
  logic               neg_r;
  logic               dbz;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  logic               is_div;
  logic               is_signed;
  logic               idle_like;
  logic               accept;
  logic               last;
  logic [WIDTH-1:0]   abs_x;
  logic [WIDTH-1:0]   abs_y;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign is_div    = op[1];
  assign is_signed = op[0];
  assign idle_like = (state == IDLE) || (state == DONE);
  assign accept    = start_i && idle_like;
  assign last      = (cnt == CW'(WIDTH - 1));

  assign abs_x = (is_signed && x[WIDTH-1]) ? -x : x;
  assign abs_y = (is_signed && y[WIDTH-1]) ? -y : y;

  // Carry out of the upper half is kept so the right shift brings it back in.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, y};
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, y};

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign hi_o = hi;
  assign lo_o = lo;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_next    = state;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    div_by_zero_o = 1'b0;
    case (state)
      IDLE: if (start_i) state_next = PREP;
      PREP: begin
        busy_o     = 1'b1;
        state_next = (is_div && (y == '0)) ? FIX : CALC;
      end
      CALC: begin
        busy_o = 1'b1;
        if (last) state_next = FIX;
      end
      FIX: begin
        busy_o     = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done_o        = 1'b1;
        div_by_zero_o = dbz;
        state_next    = start_i ? PREP : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and HI/LO register writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op    <= '0;
      x     <= '0;
      y     <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dbz   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (accept) begin
        op <= op_i;
        x  <= src1_i;
        y  <= src2_i;
      end
      if (idle_like) begin
        if (hi_we_i) hi <= hilo_wdata_i;
        if (lo_we_i) lo <= hilo_wdata_i;
      end
      case (state)
        PREP: begin
          y     <= abs_y;
          acc   <= {{WIDTH{1'b0}}, abs_x};
          neg_q <= is_signed && (x[WIDTH-1] ^ y[WIDTH-1]);
          neg_r <= is_signed && x[WIDTH-1];
          dbz   <= is_div && (y == '0);
          cnt   <= '0;
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (is_div) begin
            if (!div_diff[WIDTH]) acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else                  acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          end else begin
            if (acc[0]) acc <= {mul_sum, acc[WIDTH-1:1]};
            else        acc <= {1'b0, acc[2*WIDTH-1:1]};
          end
        end
        FIX: begin
          if (dbz) begin
            hi <= x;
            lo <= '1;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: vector table plus corner-case sequences.
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        hi_we_i;
  logic        lo_we_i;
  logic [31:0] hilo_wdata_i;
  logic        busy_o;
  logic        done_o;
  logic        div_by_zero_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;

  vec_t vecs[13];
  exp_t sb[$];

  hilo_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .op_i          (op_i),
    .src1_i        (src1_i),
    .src2_i        (src2_i),
    .hi_we_i       (hi_we_i),
    .lo_we_i       (lo_we_i),
    .hilo_wdata_i  (hilo_wdata_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .div_by_zero_o (div_by_zero_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; the start is accepted at the next posedge (edge 0).
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edbz, input int elat, input logic disturb);
    exp_t e;
    exp_t got;
    int   done_cyc;
    int   busy_bad;
    start_i = 1'b1;
    op_i    = op;
    src1_i  = a;
    src2_i  = b;
    e.hi = ehi; e.lo = elo; e.dbz = edbz; e.lat = elat;
    sb.push_back(e);
    done_cyc = 0;
    busy_bad = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) start_i = 1'b0;
      if (disturb && c == 3) begin
        start_i = 1'b1; op_i = 2'd2; src1_i = 32'd99; src2_i = 32'd3;
        hi_we_i = 1'b1; hilo_wdata_i = 32'h1234;
      end
      if (disturb && c == 7) begin
        start_i = 1'b0; hi_we_i = 1'b0;
      end
      if (done_o) begin
        done_cyc = c;
        break;
      end
      if (!busy_o) busy_bad++;
    end
    if (done_cyc == 0) begin
      failures++;
      $display("FAIL timeout_%s: no done_o within 60 cycles", name);
    end
    got = sb.pop_front();
    chk({name, "_latency"}, 64'(done_cyc), 64'(got.lat));
    chk({name, "_busy_gaps"}, 64'(busy_bad), 64'd0);
    chk({name, "_busy_in_done"}, {63'd0, busy_o}, 64'd0);
    chk({name, "_hi"}, {32'd0, hi_o}, {32'd0, got.hi});
    chk({name, "_lo"}, {32'd0, lo_o}, {32'd0, got.lo});
    chk({name, "_dbz"}, {63'd0, div_by_zero_o}, {63'd0, got.dbz});
  endtask

  initial begin
    int done_seen;
    vecs[0]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 35};
    vecs[1]  = '{2'd1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 35};
    vecs[2]  = '{2'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35};
    vecs[3]  = '{2'd2, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 35};
    vecs[4]  = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 35};
    vecs[5]  = '{2'd2, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 3};
    vecs[6]  = '{2'd0, 32'd3,        32'd4,        32'd0,        32'd12,       1'b0, 35};
    vecs[7]  = '{2'd3, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 3};
    vecs[8]  = '{2'd1, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0, 35};
    vecs[9]  = '{2'd2, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 35};
    vecs[10] = '{2'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 35};
    vecs[11] = '{2'd0, 32'h12345678, 32'd0,        32'd0,        32'd0,        1'b0, 35};
    vecs[12] = '{2'd1, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, 1'b0, 35};

    rst_i = 1'b1; start_i = 1'b0; op_i = '0; src1_i = '0; src2_i = '0;
    hi_we_i = 1'b0; lo_we_i = 1'b0; hilo_wdata_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_done", {63'd0, done_o}, 64'd0);
    chk("rst_dbz",  {63'd0, div_by_zero_o}, 64'd0);
    chk("rst_hi",   {32'd0, hi_o}, 64'd0);
    chk("rst_lo",   {32'd0, lo_o}, 64'd0);
    rst_i = 1'b0;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].lat, 1'b0);
    end

    // Back-to-back: second start issued while the first is in DONE.
    @(negedge clk);
    run_op("b2b_first", 2'd1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 35, 1'b0);
    run_op("b2b_second", 2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, 35, 1'b0);

    // Start and MTHI while busy must both be ignored.
    @(negedge clk);
    run_op("busy_ignore", 2'd0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 35, 1'b1);
    @(negedge clk);
    chk("busy_ignore_no_restart", {63'd0, busy_o}, 64'd0);

    // MTLO / MTHI in IDLE.
    lo_we_i = 1'b1; hilo_wdata_i = 32'hCAFEBABE;
    @(negedge clk);
    lo_we_i = 1'b0;
    chk("mtlo_lo", {32'd0, lo_o}, {32'd0, 32'hCAFEBABE});
    chk("mtlo_hi_kept", {32'd0, hi_o}, 64'd0);
    hi_we_i = 1'b1; hilo_wdata_i = 32'd5;
    @(negedge clk);
    hi_we_i = 1'b0; lo_we_i = 1'b1; hilo_wdata_i = 32'd6;
    @(negedge clk);
    lo_we_i = 1'b0;
    chk("mthi_hi", {32'd0, hi_o}, 64'd5);
    chk("mthi_lo", {32'd0, lo_o}, 64'd6);

    // Reset in cycle 10 of a MULTU aborts with no HI/LO write and no done.
    start_i = 1'b1; op_i = 2'd0; src1_i = 32'hFFFFFFFF; src2_i = 32'd2;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start_i = 1'b0;
    end
    chk("pre_rst_busy", {63'd0, busy_o}, 64'd1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("abort_busy", {63'd0, busy_o}, 64'd0);
    chk("abort_done", {63'd0, done_o}, 64'd0);
    chk("abort_hi", {32'd0, hi_o}, 64'd0);
    chk("abort_lo", {32'd0, lo_o}, 64'd0);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o || busy_o) done_seen++;
    end
    chk("abort_quiet", 64'(done_seen), 64'd0);
    run_op("after_rst", 2'd0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 35, 1'b0);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the MIPS datapath. It executes MULT, MULTU, DIV and DIVU with a radix-2 shift-add / restoring-divide loop of WIDTH iterations. It exposes a start/busy/done handshake so the core stalls while an operation is in flight, and it services MTHI/MTLO writes. It sits beside the ALU in the execute stage. MFHI/MFLO read hi_o/lo_o directly.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  request a new operation; sampled only in IDLE or DONE
- op_i  in  2  0=MULTU, 1=MULT, 2=DIVU, 3=DIV; sampled with start_i
- src1_i  in  WIDTH  multiplicand / dividend (rs); sampled with start_i
- src2_i  in  WIDTH  multiplier / divisor (rt); sampled with start_i
- hi_we_i  in  1  MTHI write enable
- lo_we_i  in  1  MTLO write enable
- hilo_wdata_i  in  WIDTH  data for MTHI/MTLO
- busy_o  out  1  operation in flight; core must stall
- done_o  out  1  one-cycle pulse; HI/LO hold the new result
- div_by_zero_o  out  1  pulses with done_o when a divide had src2_i == 0
- hi_o  out  WIDTH  HI register
- lo_o  out  WIDTH  LO register

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE/DONE with start_i=1 -> PREP. Operands and op are latched.
- DONE with start_i=0 -> IDLE.
- PREP: for signed ops, take absolute values and record the result signs.
  - Quotient/product sign = sign(src1) XOR sign(src2). Remainder sign = sign(src1).
  - A divide with divisor 0 goes to FIX and flags div-by-zero. Otherwise it goes to CALC with the iteration counter = 0.
- CALC: one iteration per cycle, WIDTH iterations, counter 0..WIDTH-1, then -> FIX.
  - Multiply: conditional add of the multiplicand into a 2*WIDTH accumulator, then shift right.
  - Divide: shift the remainder left, trial-subtract the divisor, and set the quotient bit when the result is non-negative (restore otherwise).
- FIX: apply two's-complement sign correction, then write HI/LO at the edge leaving FIX, then go to DONE.
  - Multiply: HI = product[2W-1:W], LO = product[W-1:0].
  - Divide: LO = quotient, HI = remainder.
  - Divide by zero: LO = all ones and HI = src1_i as latched, for both DIV and DIVU.
  - DIV of most-negative by -1: LO = most-negative, HI = 0. This falls out of the unsigned path; no special case is required.
- DONE: done_o=1 and div_by_zero_o=flag. The state lasts one cycle.
- MTHI/MTLO:
  - hi_we_i/lo_we_i take effect at the edge only when the state is IDLE or DONE. They are ignored while busy_o=1.
  - A write in the same cycle as an accepted start_i is applied. The operation's FIX write later overwrites it.
- start_i while busy_o=1 is ignored and is not queued. op_i/src changes during busy have no effect.

## Timing
- Reset (rst_i=1 at an edge): state=IDLE and counter=0. busy_o=0, done_o=0, div_by_zero_o=0, hi_o=0, lo_o=0. Reset mid-operation aborts the operation with no partial HI/LO write.
- Normal latency, with the start accepted at edge 0:
  - PREP in cycle 1.
  - CALC in cycles 2..WIDTH+1.
  - FIX in cycle WIDTH+2.
  - DONE (done_o=1, new HI/LO visible) in cycle WIDTH+3, which is cycle 35 for WIDTH=32.
- Divide-by-zero latency: PREP in cycle 1, FIX in cycle 2, DONE in cycle 3.
- busy_o = 1 exactly in PREP, CALC and FIX. It is 0 in DONE.
- A start in DONE enters PREP next cycle, giving back-to-back operations with no idle bubble.
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.

## Test plan
- MULTU 0xFFFFFFFF * 0xFFFFFFFF, start at cycle 0 -> busy_o high cycles 1-34, done_o at cycle 35, HI=0xFFFFFFFE, LO=0x00000001.
- MULT -3 * 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then back-to-back MULT 0x80000000 * 0x80000000, started in DONE -> HI=0x40000000, LO=0.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 -> LO=14, HI=2. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5 / 0 -> done_o and div_by_zero_o at cycle 3, HI=5, LO=0xFFFFFFFF. The next normal op has div_by_zero_o=0.
- While busy, assert start_i with new operands, and assert hi_we_i with data 0x1234 -> both are ignored and the original result completes. In IDLE, MTLO 0xCAFEBABE -> lo_o=0xCAFEBABE next cycle.
- rst_i at cycle 10 of a MULTU (HI/LO previously 5/6) -> next cycle busy_o=0, hi_o=0, lo_o=0, no done_o pulse. A subsequent start completes normally.
